commit_trace_monitor: RTL and testbench

COMMIT_TRACE_MONITOR -- requirements
Module: commit_trace_monitor

---
 rtl/trace_pkg.sv | 37 +++
 rtl/trace_fifo.sv | 54 +++++
 rtl/commit_trace_monitor.sv | 138 +++++++++++++
 tb/tb_commit_trace_monitor.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared trace-record definitions: record kinds, the record struct and the
// commit classification helper used by commit_trace_monitor.
package trace_pkg;

    localparam int TR_ADDR_W = 16;
    localparam int TR_DATA_W = 16;
    localparam int TR_REG_W  = 4;
    localparam int SEQ_W     = 32;

    typedef enum logic [2:0] {
        KIND_REG   = 3'd0,
        KIND_LOAD  = 3'd1,
        KIND_STORE = 3'd2,
        KIND_OTHER = 3'd3,
        KIND_HALT  = 3'd4
    } kind_e;

    typedef struct packed {
        kind_e                  kind;
        logic [SEQ_W-1:0]       seq;
        logic [TR_ADDR_W-1:0]   pc;
        logic [TR_ADDR_W-1:0]   addr;
        logic [TR_REG_W-1:0]    dst;
        logic [TR_DATA_W-1:0]   data;
    } trace_rec_t;

    // Halt outranks everything; a register-writing load is a LOAD, not a REG.
    function automatic kind_e classify(input logic halt, input logic regwrite,
                                       input logic memread, input logic memwrite);
        if (halt)                     return KIND_HALT;
        else if (regwrite && memread) return KIND_LOAD;
        else if (regwrite)            return KIND_REG;
        else if (memwrite)            return KIND_STORE;
        else                          return KIND_OTHER;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO for trace records; output is the registered head entry.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         pop_i,
    output logic [W-1:0] rd_data_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                       (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign rd_data_o = mem_q[rd_ptr_q[PW-1:0]];

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/commit_trace_monitor.sv
// Turns the commit stream into sequenced trace records and tracks run status.
// Optional cycle watchdog (TIMEOUT state) compiled in with CTM_WATCHDOG_EN.
module commit_trace_monitor
    import trace_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 8,
    parameter int MAX_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cm_valid,
    input  logic [ADDR_W-1:0] cm_pc,
    input  logic              cm_regwrite,
    input  logic [REG_W-1:0]  cm_dstreg,
    input  logic [DATA_W-1:0] cm_wdata,
    input  logic              cm_memread,
    input  logic              cm_memwrite,
    input  logic [ADDR_W-1:0] cm_addr,
    input  logic [DATA_W-1:0] cm_mdata,
    input  logic              cm_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_kind,
    output logic [31:0]       out_seq,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_addr,
    output logic [REG_W-1:0]  out_reg,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       inst_count,
    output logic [31:0]       cycle_count,
    output logic              halted,
    output logic              done,
    output logic              timeout,
    output logic              overflow
);

    if (ADDR_W > TR_ADDR_W || DATA_W > TR_DATA_W || REG_W > TR_REG_W ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_CYCLES < 1) begin : g_param_chk
        $error("commit_trace_monitor: unsupported parameter set");
    end

`ifdef CTM_WATCHDOG_EN
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE, ST_TIMEOUT} state_e;
`else
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] inst_count_q, inst_count_d;
    logic [31:0] cycle_count_q, cycle_count_d;
    logic        overflow_q, overflow_d;

    kind_e       kind;
    trace_rec_t  wr_rec, rd_rec;
    logic        take, pop, fifo_empty, fifo_full;

    assign take = cm_valid && (state_q == ST_RUN);
    assign kind = classify(cm_halt, cm_regwrite, cm_memread, cm_memwrite);
    assign pop  = !fifo_empty && out_ready;

    always_comb begin
        wr_rec      = '0;
        wr_rec.kind = kind;
        wr_rec.seq  = inst_count_q;
        wr_rec.pc   = TR_ADDR_W'(cm_pc);
        wr_rec.addr = TR_ADDR_W'(cm_addr);
        wr_rec.dst  = TR_REG_W'(cm_dstreg);
        wr_rec.data = (kind == KIND_STORE) ? TR_DATA_W'(cm_mdata) : TR_DATA_W'(cm_wdata);
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(trace_rec_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (take),
        .wr_data_i (wr_rec),
        .pop_i     (pop),
        .rd_data_o (rd_rec),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    always_comb begin
        inst_count_d  = inst_count_q + {31'd0, take};
        cycle_count_d = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q : cycle_count_q + 32'd1;
        overflow_d    = overflow_q || (take && fifo_full && !pop);
        state_d       = state_q;
        case (state_q)
            ST_RUN: begin
                // A halt wins over the watchdog, and counts even if its record is dropped.
                if (take && kind == KIND_HALT) state_d = ST_DRAIN;
`ifdef CTM_WATCHDOG_EN
                else if (cycle_count_q >= 32'(MAX_CYCLES - 1)) state_d = ST_TIMEOUT;
`endif
            end
            ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
            default:  state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            inst_count_q  <= '0;
            cycle_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            inst_count_q  <= inst_count_d;
            cycle_count_q <= cycle_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign out_valid   = !fifo_empty;
    assign out_kind    = rd_rec.kind;
    assign out_seq     = rd_rec.seq;
    assign out_pc      = ADDR_W'(rd_rec.pc);
    assign out_addr    = ADDR_W'(rd_rec.addr);
    assign out_reg     = REG_W'(rd_rec.dst);
    assign out_data    = DATA_W'(rd_rec.data);
    assign inst_count  = inst_count_q;
    assign cycle_count = cycle_count_q;
    assign overflow    = overflow_q;
    assign halted      = (state_q == ST_DRAIN) || (state_q == ST_DONE);
    assign done        = (state_q == ST_DONE);
`ifdef CTM_WATCHDOG_EN
    assign timeout     = (state_q == ST_TIMEOUT);
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_commit_trace_monitor.sv
// Scoreboard bench for commit_trace_monitor: a queue-based reference model
// predicts records and status; a negedge monitor checks every accepted record.
`timescale 1ns/1ps
module tb_commit_trace_monitor;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int RW    = 4;
    localparam int DEPTH = 8;
    localparam int MAXC  = 50;
`ifdef CTM_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam int PH_RUN = 0, PH_DRAIN = 1, PH_DONE = 2, PH_TIMEOUT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cm_valid, cm_regwrite, cm_memread, cm_memwrite, cm_halt;
    logic [AW-1:0] cm_pc, cm_addr;
    logic [RW-1:0] cm_dstreg;
    logic [DW-1:0] cm_wdata, cm_mdata;
    logic          out_valid, out_ready;
    logic [2:0]    out_kind;
    logic [31:0]   out_seq, inst_count, cycle_count;
    logic [AW-1:0] out_pc, out_addr;
    logic [RW-1:0] out_reg;
    logic [DW-1:0] out_data;
    logic          halted, done, timeout, overflow;

    always #5 clk = ~clk;

    commit_trace_monitor #(
        .ADDR_W(AW), .DATA_W(DW), .REG_W(RW), .DEPTH(DEPTH), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .rst(rst),
        .cm_valid(cm_valid), .cm_pc(cm_pc), .cm_regwrite(cm_regwrite),
        .cm_dstreg(cm_dstreg), .cm_wdata(cm_wdata), .cm_memread(cm_memread),
        .cm_memwrite(cm_memwrite), .cm_addr(cm_addr), .cm_mdata(cm_mdata),
        .cm_halt(cm_halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_seq(out_seq), .out_pc(out_pc), .out_addr(out_addr), .out_reg(out_reg),
        .out_data(out_data), .inst_count(inst_count), .cycle_count(cycle_count),
        .halted(halted), .done(done), .timeout(timeout), .overflow(overflow)
    );

    typedef struct {
        int kind;
        int seq;
        int pc;
        int addr;
        int dst;
        int data;
    } exp_t;

    exp_t    sbq[$];
    exp_t    mon_e;
    int      checks = 0;
    int      failures = 0;
    int      n_popped = 0;

    // Reference model state (spec-level view of the monitor)
    int      m_occ, m_inst, m_phase;
    longint  m_cyc;
    bit      m_ovf;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_kind(input bit h, input bit rw, input bit mr, input bit mw);
        if (h)        return 4;
        if (rw && mr) return 1;
        if (rw)       return 0;
        if (mw)       return 2;
        return 3;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            chk("record_expected", longint'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                n_popped++;
                chk("out_kind", out_kind, mon_e.kind);
                chk("out_seq", out_seq, mon_e.seq);
                chk("out_pc", out_pc, mon_e.pc);
                if (mon_e.kind == 0 || mon_e.kind == 1) begin
                    chk("out_reg", out_reg, mon_e.dst);
                    chk("out_data_wdata", out_data, mon_e.data);
                end
                if (mon_e.kind == 1 || mon_e.kind == 2) chk("out_addr", out_addr, mon_e.addr);
                if (mon_e.kind == 2) chk("out_data_mdata", out_data, mon_e.data);
            end
        end
    end

    task automatic set_idle();
        cm_valid = 0; cm_halt = 0; cm_regwrite = 0; cm_memread = 0; cm_memwrite = 0;
        cm_pc = '0; cm_addr = '0; cm_dstreg = '0; cm_wdata = '0; cm_mdata = '0;
    endtask

    task automatic set_commit(input bit h, input bit rw, input bit mr, input bit mw,
                              input int pc, input int dst, input int wd,
                              input int addr, input int md);
        cm_valid = 1; cm_halt = h; cm_regwrite = rw; cm_memread = mr; cm_memwrite = mw;
        cm_pc = AW'(pc); cm_dstreg = RW'(dst); cm_wdata = DW'(wd);
        cm_addr = AW'(addr); cm_mdata = DW'(md);
    endtask

    task automatic check_status();
        chk("inst_count", inst_count, m_inst);
        chk("cycle_count", cycle_count, m_cyc);
        chk("out_valid", out_valid, longint'(m_occ > 0));
        chk("overflow", overflow, m_ovf);
        chk("halted", halted, longint'(m_phase == PH_DRAIN || m_phase == PH_DONE));
        chk("done", done, longint'(m_phase == PH_DONE));
        chk("timeout", timeout, longint'(m_phase == PH_TIMEOUT));
    endtask

    // One clock: check current status, advance the model by this cycle's inputs, clock.
    task automatic step();
        exp_t e;
        int   occ_now, k;
        bit   pop_m, take, push_m;
        check_status();
        occ_now = m_occ;
        pop_m   = (occ_now > 0) && out_ready;
        take    = cm_valid && (m_phase == PH_RUN);
        k       = exp_kind(cm_halt, cm_regwrite, cm_memread, cm_memwrite);
        push_m  = 1'b0;
        if (take) begin
            e.kind = k; e.seq = m_inst; e.pc = int'(cm_pc); e.addr = int'(cm_addr);
            e.dst  = int'(cm_dstreg);
            e.data = (k == 2) ? int'(cm_mdata) : int'(cm_wdata);
            if (occ_now < DEPTH || pop_m) begin
                sbq.push_back(e);
                push_m = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
            m_inst++;
        end
        m_occ = occ_now + int'(push_m) - int'(pop_m);
        if (m_phase == PH_RUN) begin
            if (take && k == 4)                 m_phase = PH_DRAIN;
            else if (WD_EN && m_cyc + 1 >= MAXC) m_phase = PH_TIMEOUT;
        end else if (m_phase == PH_DRAIN && occ_now == 0) begin
            m_phase = PH_DONE;
        end
        if (m_cyc != 64'hFFFF_FFFF) m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sbq.delete();
        m_occ = 0; m_inst = 0; m_cyc = 0; m_phase = PH_RUN; m_ovf = 1'b0;
        n_popped = 0;
    endtask

    task automatic drain_and_check(input string name);
        set_idle();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) step();
        chk(name, sbq.size(), 0);
    endtask

    task automatic random_commit();
        int r;
        r = $urandom_range(0, 29);
        set_commit(r == 0, 1'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 65535)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                   int'($urandom_range(0, 65535)));
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: bench did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        out_ready = 1'b0;
        do_reset();
        step();

        // Basic REG / LOAD / STORE sequence with a ready consumer
        out_ready = 1'b1;
        set_commit(0, 1, 0, 0, 16'h0000, 3, 16'h00AA, 0, 0);          step();
        set_commit(0, 1, 1, 0, 16'h0002, 4, 16'h1234, 16'h0010, 0);   step();
        set_commit(0, 0, 0, 1, 16'h0004, 0, 0, 16'h0020, 16'h5555);   step();
        drain_and_check("basic_sb_empty");
        chk("basic_inst_count", inst_count, 3);
        chk("basic_records", n_popped, 3);

        // Ten commits into a stalled FIFO: two dropped, overflow sticky
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_commit(0, 1, 0, 0, 2 * i, i, 16'h0100 + i, 0, 0);
            step();
        end
        set_idle();
        step();
        chk("ovf_flag", overflow, 1);
        chk("ovf_inst_count", inst_count, 10);
        drain_and_check("ovf_sb_empty");
        chk("ovf_records", n_popped, 8);

        // Full FIFO with simultaneous push and pop: nothing dropped
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_commit(0, 0, 0, 1, i, 0, 0, 16'h0200 + i, 16'h0A00 + i);
            step();
        end
        out_ready = 1'b1;
        set_commit(0, 1, 0, 0, 16'h0040, 7, 16'hBEEF, 0, 0);
        step();
        out_ready = 1'b0;
        set_idle();
        step();
        chk("pushpop_overflow", overflow, 0);
        drain_and_check("pushpop_sb_empty");
        chk("pushpop_records", n_popped, 9);

        // Halt while stalled: drain, ignore later commits, then done
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_commit(0, 1, 0, 0, 16'h0300 + i, i, 16'h0030 + i, 0, 0);
            step();
        end
        set_commit(1, 0, 0, 0, 16'h0310, 0, 0, 0, 0);
        step();
        chk("halt_halted", halted, 1);
        chk("halt_done", done, 0);
        set_commit(0, 1, 0, 0, 16'h0320, 9, 16'h0999, 0, 0);
        step();
        chk("halt_ignored_inst", inst_count, 4);
        drain_and_check("halt_sb_empty");
        chk("halt_records", n_popped, 4);
        chk("halt_done_final", done, 1);

        // Watchdog: idle to cycle 60, then reset and confirm clean state
        do_reset();
        out_ready = 1'b1;
        set_idle();
        for (int i = 0; i < 60; i++) step();
        chk("wd_cycle_count", cycle_count, 60);
        chk("wd_timeout", timeout, longint'(WD_EN));
        do_reset();
        step();
        chk("wd_reset_cycles", cycle_count, 1);

        // Randomized episodes, including resets mid-operation
        for (int ep = 0; ep < 8; ep++) begin
            int rdy_pct;
            do_reset();
            rdy_pct = $urandom_range(10, 90);
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 99) < 70) random_commit();
                else set_idle();
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                step();
                if (ep == 7 && c == 20) break;
            end
            if (ep != 7) drain_and_check("rand_sb_empty");
        end
        do_reset();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
